// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL opcodes, packet width helpers and the burst-length decode
// used by the UL arbiter.
package tl_ul_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] GET             = 3'd4;

  typedef enum logic {ARB, BURST} arb_st_e;

  function automatic int AW_PKT(int rs, int aw);
    return 3 + 3 + 4 + rs + aw + 4 + 32 + 1;
  endfunction

  function automatic int DW_PKT(int rs);
    return 3 + 2 + 4 + rs + 1 + 32 + 1;
  endfunction

  // Beats still to come after the first one (beats-1); sizes above 12 clamp to 1024 beats.
  function automatic logic [9:0] beats_from_size(logic [3:0] size);
    if (size <= 4'd2)  return 10'd0;
    if (size >= 4'd12) return 10'd1023;
    return 10'((11'd1 << (size - 4'd2)) - 11'd1);
  endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Combinational cyclic picker: first requester at or after ptr wins.
// Returns a one-hot grant and its encoded index.
module tl_rr_picker #(
  parameter  int NUM_M = 2,
  localparam int IDW   = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [IDW-1:0]   idx
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    // Scan farthest-first so the nearest requester to ptr overwrites last.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_M) j = j - NUM_M;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/tl_ul_arbiter.sv
// N:1 TileLink-UL arbiter: round-robin A grant with Put burst lock, registered A
// output and per-master outstanding cap; D routed back by a source-ID prefix.
// Define TL_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module tl_ul_arbiter
  import tl_ul_pkg::*;
#(
  parameter  int NUM_M   = 2,
  parameter  int TL_RS   = 4,
  parameter  int TL_AW   = 28,
  parameter  int MAX_OUT = 4,
  localparam int IDW     = $clog2(NUM_M),
  localparam int AWP     = AW_PKT(TL_RS, TL_AW),
  localparam int DWP     = DW_PKT(TL_RS)
) (
  input  logic                 tilelink_clock_i,
  input  logic                 tilelink_reset_i,
  input  logic [NUM_M*AWP-1:0] s_a_pkt,
  input  logic [NUM_M-1:0]     s_a_valid,
  output logic [NUM_M-1:0]     s_a_ready,
  output logic [DWP-1:0]       s_d_pkt,
  output logic [NUM_M-1:0]     s_d_valid,
  input  logic [NUM_M-1:0]     s_d_ready,
  output logic [AWP+IDW-1:0]   m_a_pkt,
  output logic                 m_a_valid,
  input  logic                 m_a_ready,
  input  logic [DWP+IDW-1:0]   m_d_pkt,
  input  logic                 m_d_valid,
  output logic                 m_d_ready
);

  localparam int ASRC = TL_AW + 37;   // lsb of the A source field
  localparam int DSRC = 34;           // lsb of the D source field
  localparam int DHI  = DWP + IDW;
  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_OUT);

  logic [NUM_M-1:0][AWP-1:0] a_pkt;
  logic [NUM_M-1:0][CW-1:0]  out_cnt;
  logic [NUM_M-1:0]          elig, pick_oh, rdy;
  logic [IDW-1:0]            pick_idx, ptr, sel, owner_q, owner_d;
  logic [9:0]                a_beats_q, a_beats_d;
  arb_st_e                   st_q, st_d;
  logic                      adv, acc, a_last, a_burst;
  logic [2:0]                a_op;
  logic [3:0]                a_size;
  logic [AWP-1:0]            sel_pkt;

  assign a_pkt = s_a_pkt;
  assign adv   = ~m_a_valid | m_a_ready;

  for (genvar i = 0; i < NUM_M; i++) begin : g_elig
    assign elig[i] = s_a_valid[i] & (out_cnt[i] != CAP);
  end

  tl_rr_picker #(.NUM_M(NUM_M)) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx)
  );

`ifdef TL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] rr_ptr;
  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i)        rr_ptr <= '0;
    else if (st_q == ARB && acc) rr_ptr <= (int'(pick_idx) == NUM_M - 1) ? '0 : pick_idx + 1'b1;
  end
  assign ptr = rr_ptr;
`endif

  assign a_op    = a_pkt[pick_idx][AWP-1 -: 3];
  assign a_size  = a_pkt[pick_idx][AWP-7 -: 4];
  assign a_burst = (a_op == PUT_FULL || a_op == PUT_PARTIAL) && a_size > 4'd2;
  assign sel     = (st_q == BURST) ? owner_q : pick_idx;
  assign sel_pkt = a_pkt[sel];

  always_comb begin
    st_d      = st_q;
    owner_d   = owner_q;
    a_beats_d = a_beats_q;
    rdy       = '0;
    acc       = 1'b0;
    a_last    = 1'b0;
    case (st_q)
      ARB: if (adv && |elig) begin
        rdy = pick_oh;
        acc = 1'b1;
        if (a_burst) begin
          st_d      = BURST;
          owner_d   = pick_idx;
          a_beats_d = beats_from_size(a_size);
        end else begin
          a_last = 1'b1;
        end
      end
      BURST: begin
        // Owner keeps the port even while it stalls; the cap does not apply here.
        rdy[owner_q] = adv;
        acc          = adv & s_a_valid[owner_q];
        if (acc) begin
          a_beats_d = a_beats_q - 10'd1;
          if (a_beats_q == 10'd1) begin
            st_d   = ARB;
            a_last = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (tilelink_reset_i) begin
      rdy    = '0;
      acc    = 1'b0;
      a_last = 1'b0;
    end
  end

  assign s_a_ready = rdy;

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      st_q      <= ARB;
      owner_q   <= '0;
      a_beats_q <= '0;
      m_a_valid <= 1'b0;
      m_a_pkt   <= '0;
    end else begin
      st_q      <= st_d;
      owner_q   <= owner_d;
      a_beats_q <= a_beats_d;
      if (adv) begin
        m_a_valid <= acc;
        if (acc) m_a_pkt <= {sel_pkt[AWP-1:ASRC+TL_RS], sel, sel_pkt[ASRC+TL_RS-1:0]};
      end
    end
  end

  // D channel: combinational route by the id prefix on the downstream source.
  logic [IDW-1:0] d_id;
  logic [2:0]     d_op;
  logic [3:0]     d_size;
  logic [9:0]     d_beats, d_rem;
  logic           d_busy, d_fire, d_last;

  assign d_id    = m_d_pkt[DSRC+TL_RS +: IDW];
  assign d_op    = m_d_pkt[DHI-1 -: 3];
  assign d_size  = m_d_pkt[DHI-6 -: 4];
  assign s_d_pkt = {m_d_pkt[DHI-1:DSRC+TL_RS+IDW], m_d_pkt[DSRC+TL_RS-1:0]};

  always_comb begin
    s_d_valid = '0;
    m_d_ready = 1'b0;
    if (int'(d_id) < NUM_M) begin
      s_d_valid[d_id] = m_d_valid;
      m_d_ready       = s_d_ready[d_id];
    end
  end

  assign d_rem  = d_busy ? d_beats
                : (d_op == ACCESS_ACK_DATA) ? beats_from_size(d_size) : 10'd0;
  assign d_fire = m_d_valid & m_d_ready;
  assign d_last = d_fire & (d_rem == 10'd0);

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      d_busy  <= 1'b0;
      d_beats <= '0;
    end else if (d_fire) begin
      d_busy <= (d_rem != 10'd0);
      if (d_rem != 10'd0) d_beats <= d_rem - 10'd1;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_cnt
    logic inc, dec;
    assign inc = a_last & (sel == IDW'(i));
    assign dec = d_last & (d_id == IDW'(i));
    always_ff @(posedge tilelink_clock_i) begin
      if (tilelink_reset_i)                        out_cnt[i] <= '0;
      else if (inc && !dec)                        out_cnt[i] <= out_cnt[i] + 1'b1;
      else if (dec && !inc && out_cnt[i] != '0)    out_cnt[i] <= out_cnt[i] - 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Directed bench for tl_ul_arbiter (2 masters, RS=4, AW=28, MAX_OUT=4, round-robin build).
module tb_tl_ul_arbiter;
  import tl_ul_pkg::*;

  localparam int NM  = 2;
  localparam int AWP = 79;
  localparam int DWP = 47;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NM-1:0][AWP-1:0] a_in;
  logic [NM*AWP-1:0]      s_a_pkt;
  logic [NM-1:0]          s_a_valid, s_a_ready, s_d_valid, s_d_ready;
  logic [DWP-1:0]         s_d_pkt;
  logic [AWP:0]           m_a_pkt;
  logic                   m_a_valid, m_a_ready, m_d_valid, m_d_ready;
  logic [DWP:0]           m_d_pkt;
  int                     errors = 0;
  int                     checks = 0;

  assign s_a_pkt = a_in;
  always #5 clk = ~clk;

  tl_ul_arbiter #(.NUM_M(NM), .TL_RS(4), .TL_AW(28), .MAX_OUT(4)) dut (
    .tilelink_clock_i (clk),
    .tilelink_reset_i (rst),
    .s_a_pkt          (s_a_pkt),
    .s_a_valid        (s_a_valid),
    .s_a_ready        (s_a_ready),
    .s_d_pkt          (s_d_pkt),
    .s_d_valid        (s_d_valid),
    .s_d_ready        (s_d_ready),
    .m_a_pkt          (m_a_pkt),
    .m_a_valid        (m_a_valid),
    .m_a_ready        (m_a_ready),
    .m_d_pkt          (m_d_pkt),
    .m_d_valid        (m_d_valid),
    .m_d_ready        (m_d_ready)
  );

  function automatic logic [AWP-1:0] ua(logic [2:0] op, logic [3:0] sz, logic [3:0] src,
                                        logic [27:0] adr, logic [31:0] dat);
    return {op, 3'd0, sz, src, adr, 4'hF, dat, 1'b0};
  endfunction

  function automatic logic [AWP:0] da(logic [2:0] op, logic [3:0] sz, logic id, logic [3:0] src,
                                      logic [27:0] adr, logic [31:0] dat);
    return {op, 3'd0, sz, id, src, adr, 4'hF, dat, 1'b0};
  endfunction

  function automatic logic [DWP:0] dd(logic [2:0] op, logic [3:0] sz, logic id, logic [3:0] src,
                                      logic [31:0] dat);
    return {op, 2'd0, sz, id, src, 1'b0, dat, 1'b0};
  endfunction

  function automatic logic [DWP-1:0] ud(logic [2:0] op, logic [3:0] sz, logic [3:0] src,
                                        logic [31:0] dat);
    return {op, 2'd0, sz, src, 1'b0, dat, 1'b0};
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic chk_v(input string tag, input logic [NM-1:0] obs, input logic [NM-1:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
  endtask

  task automatic chk_a(input string tag, input logic [AWP:0] obs, input logic [AWP:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic chk_d(input string tag, input logic [DWP-1:0] obs, input logic [DWP-1:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    a_in = '0; s_a_valid = '0; s_d_ready = '1; m_a_ready = 1'b1; m_d_valid = 1'b0; m_d_pkt = '0;
    rst = 1'b1;
    cyc(); cyc();

    // reset: requests present but nothing granted or emitted
    a_in[0] = ua(GET, 4'd2, 4'd1, 28'h0, 32'h0);
    a_in[1] = ua(GET, 4'd2, 4'd2, 28'h0, 32'h0);
    s_a_valid = 2'b11;
    mid();
    chk_b("rst_m_a_valid", m_a_valid, 1'b0);
    chk_a("rst_m_a_pkt", m_a_pkt, '0);
    chk_v("rst_s_a_ready", s_a_ready, 2'b00);
    cyc();
    rst = 1'b0; s_a_valid = '0;

    // single Get from m0, then AccessAckData routed back
    a_in[0] = ua(GET, 4'd2, 4'd3, 28'h100, 32'h0);
    s_a_valid = 2'b01;
    mid();
    chk_v("get_ready", s_a_ready, 2'b01);
    cyc();
    s_a_valid = '0;
    m_d_pkt = dd(ACCESS_ACK_DATA, 4'd2, 1'b0, 4'd3, 32'hDEADBEEF);
    m_d_valid = 1'b1;
    mid();
    chk_b("get_m_a_valid", m_a_valid, 1'b1);
    chk_a("get_m_a_pkt", m_a_pkt, da(GET, 4'd2, 1'b0, 4'd3, 28'h100, 32'h0));
    chk_v("get_s_d_valid", s_d_valid, 2'b01);
    chk_d("get_s_d_pkt", s_d_pkt, ud(ACCESS_ACK_DATA, 4'd2, 4'd3, 32'hDEADBEEF));
    chk_b("get_m_d_ready", m_d_ready, 1'b1);
    cyc();
    m_d_valid = 1'b0;

    // contention: pointer sits at 1 after the m0 grant, so m1 leads
    a_in[0] = ua(GET, 4'd2, 4'd1, 28'h200, 32'h0);
    a_in[1] = ua(GET, 4'd2, 4'd2, 28'h300, 32'h0);
    s_a_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk_v("rr_grant", s_a_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0)
        chk_a("rr_m_a_pkt", m_a_pkt, (k % 2 == 1) ? da(GET, 4'd2, 1'b1, 4'd2, 28'h300, 32'h0)
                                                  : da(GET, 4'd2, 1'b0, 4'd1, 28'h200, 32'h0));
      cyc();
    end
    s_a_valid = '0;
    m_d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_d_pkt = dd(ACCESS_ACK_DATA, 4'd2, k[0], 4'd1, 32'h0);
      mid();
      if (k == 0) chk_a("rr_last_pkt", m_a_pkt, da(GET, 4'd2, 1'b0, 4'd1, 28'h200, 32'h0));
      chk_v("rr_drain_route", s_d_valid, k[0] ? 2'b10 : 2'b01);
      cyc();
    end
    m_d_valid = 1'b0;

    // burst lock: m1 4-beat PutFull, m0 Get waiting throughout
    a_in[0] = ua(GET, 4'd2, 4'd4, 28'h400, 32'h0);
    s_a_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) a_in[1] = ua(PUT_FULL, 4'd4, 4'd6, 28'h500, 32'h1000 + k);
      else       s_a_valid = 2'b01;
      mid();
      chk_v("burst_grant", s_a_ready, (k < 4) ? 2'b10 : 2'b01);
      if (k > 0) chk_a("burst_beat", m_a_pkt, da(PUT_FULL, 4'd4, 1'b1, 4'd6, 28'h500, 32'h1000 + k - 1));
      cyc();
    end
    s_a_valid = '0;
    m_d_valid = 1'b1;
    m_d_pkt = dd(ACCESS_ACK_DATA, 4'd2, 1'b0, 4'd4, 32'h0);
    mid();
    chk_a("burst_then_m0", m_a_pkt, da(GET, 4'd2, 1'b0, 4'd4, 28'h400, 32'h0));
    cyc();
    m_d_pkt = dd(ACCESS_ACK, 4'd4, 1'b1, 4'd6, 32'h0);
    mid();
    chk_v("burst_ack_route", s_d_valid, 2'b10);
    cyc();
    m_d_valid = 1'b0;

    // outstanding cap: four Gets accepted, fifth held until a 4-beat AccessAckData completes
    a_in[0] = ua(GET, 4'd2, 4'd5, 28'h600, 32'h0);
    s_a_valid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk_v("cap_ready", s_a_ready, (k < 4) ? 2'b01 : 2'b00);
      cyc();
    end
    m_d_valid = 1'b1;
    s_d_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      m_d_pkt = dd(ACCESS_ACK_DATA, 4'd4, 1'b0, 4'd5, 32'hA0 + k);
      mid();
      chk_v("cap_hold", s_a_ready, 2'b00);
      if (k == 3) chk_d("cap_d_pkt", s_d_pkt, ud(ACCESS_ACK_DATA, 4'd4, 4'd5, 32'hA3));
      cyc();
    end
    m_d_valid = 1'b0;
    mid();
    chk_v("cap_release", s_a_ready, 2'b01);
    cyc();

    // backpressure on m_a, plus an unready D response for m1
    a_in[1] = ua(GET, 4'd2, 4'd9, 28'h700, 32'h0);
    s_a_valid = 2'b10;
    m_a_ready = 1'b0;
    m_d_pkt = dd(ACCESS_ACK, 4'd2, 1'b1, 4'd9, 32'h0);
    m_d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk_a("bp_hold_pkt", m_a_pkt, da(GET, 4'd2, 1'b0, 4'd5, 28'h600, 32'h0));
      chk_b("bp_hold_valid", m_a_valid, 1'b1);
      chk_v("bp_ready", s_a_ready, 2'b00);
      chk_b("bp_m_d_ready", m_d_ready, 1'b0);
      cyc();
    end
    m_a_ready = 1'b1;
    m_d_valid = 1'b0;
    s_d_ready = 2'b11;
    mid();
    chk_v("bp_release", s_a_ready, 2'b10);
    cyc();
    s_a_valid = '0;
    mid();
    chk_a("bp_m1_out", m_a_pkt, da(GET, 4'd2, 1'b1, 4'd9, 28'h700, 32'h0));
    cyc();

    // reset in the middle of a 4-beat Put from m1 (m0 is sitting at its cap)
    a_in[1] = ua(PUT_FULL, 4'd4, 4'd10, 28'h800, 32'hB0);
    s_a_valid = 2'b10;
    mid();
    chk_v("rput_beat0", s_a_ready, 2'b10);
    cyc();
    a_in[1] = ua(PUT_FULL, 4'd4, 4'd10, 28'h800, 32'hB1);
    mid();
    chk_v("rput_beat1", s_a_ready, 2'b10);
    cyc();
    a_in[1] = ua(PUT_FULL, 4'd4, 4'd10, 28'h800, 32'hB2);
    rst = 1'b1;
    mid();
    chk_v("rput_in_reset", s_a_ready, 2'b00);
    cyc();
    rst = 1'b0;
    a_in[0] = ua(GET, 4'd2, 4'd11, 28'h900, 32'h0);
    a_in[1] = ua(GET, 4'd2, 4'd12, 28'hA00, 32'h0);
    s_a_valid = 2'b11;
    mid();
    chk_b("post_rst_valid", m_a_valid, 1'b0);
    chk_v("post_rst_grant_m0", s_a_ready, 2'b01);
    cyc();
    s_a_valid = 2'b10;
    mid();
    chk_v("post_rst_grant_m1", s_a_ready, 2'b10);
    chk_a("post_rst_m0_pkt", m_a_pkt, da(GET, 4'd2, 1'b0, 4'd11, 28'h900, 32'h0));
    cyc();
    s_a_valid = '0;
    mid();
    chk_a("post_rst_m1_pkt", m_a_pkt, da(GET, 4'd2, 1'b1, 4'd12, 28'hA00, 32'h0));
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_ul_arbiter.md
Name: tl_ul_arbiter

Overview:
- N:1 TileLink-UL arbiter that shares one lightweight (LW) slave port between NUM_M upstream masters, e.g. the HW-to-LW bridge plus a DMA engine.
- A channel: round-robin grant with burst lock for multi-beat Put, a registered output stage, and a per-master outstanding-transaction cap.
- D channel: routed back by a master-ID prefix prepended to a_source.

Parameters:
- NUM_M, 2, number of upstream masters (2..8)
- TL_RS, 4, upstream source width; downstream source width is TL_RS+IDW, with IDW=$clog2(NUM_M)
- TL_AW, 28, address width
- MAX_OUT, 4, maximum outstanding transactions per master (1..15)

Ports:
- tilelink_clock_i  in  1  clock
- tilelink_reset_i  in  1  synchronous active-high reset
- s_a_pkt  in  NUM_M*AW_PKT  per-master A packet {opcode[3],param[3],size[4],source[TL_RS],address[TL_AW],mask[4],data[32],corrupt}; master i in slice i
- s_a_valid  in  NUM_M  per-master A valid
- s_a_ready  out  NUM_M  per-master A ready
- s_d_pkt  out  DW_PKT  D packet {opcode[3],param[2],size[4],source[TL_RS],denied,data[32],corrupt}, broadcast to all masters
- s_d_valid  out  NUM_M  per-master D valid
- s_d_ready  in  NUM_M  per-master D ready
- m_a_pkt  out  AW_PKT+IDW  downstream A packet; source = {id,source}
- m_a_valid  out  1  downstream A valid
- m_a_ready  in  1  downstream A ready
- m_d_pkt  in  DW_PKT+IDW  downstream D packet
- m_d_valid  in  1  downstream D valid
- m_d_ready  out  1  downstream D ready

Behaviour:
- Reset: m_a_valid=0, m_a_pkt=0, s_a_ready=0, lock=0, rr_ptr=0, all outstanding counters=0, both beat counters=0.
- A output register: accepts a beat when ~m_a_valid | m_a_ready (adv). Latency is 1 cycle from s_a accept to m_a_valid. Back-to-back at full rate is supported.
- Eligibility: master i is eligible when s_a_valid[i] & (out_cnt[i] != MAX_OUT).
  - A continuation beat of a locked burst ignores the cap.
- ARB state (lock=0):
  - If adv, grant the first eligible master at or after rr_ptr (cyclic).
  - s_a_ready[g]=1 for that cycle only; the register loads {g, pkt}.
  - rr_ptr <= g+1 mod NUM_M.
  - If opcode is PutFull(0) or PutPartial(1) and size>2: lock=1, owner=g, a_beats=2^(size-2)-1.
- BURST state (lock=1):
  - Only the owner is considered. s_a_ready[owner] = adv.
  - Each accepted beat decrements a_beats. Reaching 0 returns to ARB.
  - The owner deasserting valid mid-burst stalls; there is no re-arbitration.
- Get(4) is single-beat on A regardless of size.
- Sizes >12 are treated as 12 (1024 beats). Beat counters are 10 bits.
- Outstanding accounting:
  - out_cnt[id] increments on acceptance of the last (or only) A beat of a message.
  - out_cnt[id] decrements on the last D beat routed to id.
  - Both in the same cycle for the same id: count unchanged.
- D routing is combinational:
  - id = m_d_source MSBs.
  - s_d_valid[id] = m_d_valid; other bits 0.
  - m_d_ready = s_d_ready[id].
  - s_d_pkt is m_d_pkt with the id stripped.
- D beat count: AccessAckData(1) with size>2 has 2^(size-2) beats. Count d_beats down; the last beat is where d_beats==0. Other opcodes are single beat.
- Reset mid-burst: lock, counters and valid clear next edge; upstream is responsible for restarting.
- Backpressure on m_a_ready with m_a_valid=1: the register holds its contents stable.

Optional Feature:
- TL_ARB_FIXED_PRIO_EN
  - Defined: grant is the lowest-index eligible master; rr_ptr is not implemented. Burst lock and outstanding cap are unchanged.
  - Undefined: round-robin as above.

Decomposition:
- Package tl_ul_pkg holds:
  - opcode localparams: PUT_FULL=0, PUT_PARTIAL=1, ACCESS_ACK=0, ACCESS_ACK_DATA=1, GET=4
  - AW_PKT(TL_RS,TL_AW) and DW_PKT(TL_RS) width functions
  - beats_from_size() function
- One sub-module, tl_rr_picker: combinational NUM_M round-robin/priority picker taking req, ptr and returning a one-hot grant plus encoded index.

Test Plan:
- Single Get:
  - Stimulus: m0 Get size=2 addr 0x100 src 3.
  - Response: m_a valid 1 cycle later with source {0,3}. m_d AccessAckData source {0,3} gives s_d_valid=01, data forwarded.
- Contention:
  - Stimulus: m0 and m1 both valid continuously with Get, m_a_ready=1.
  - Response: grants alternate m0,m1,m0,m1. With TL_ARB_FIXED_PRIO_EN, only m0 is granted while it is valid.
- Burst lock:
  - Stimulus: m1 PutFull size=4 (4 beats) with m0 valid throughout.
  - Response: 4 consecutive m1 beats on m_a; m0 is granted only after the 4th beat.
- Outstanding cap:
  - Stimulus: MAX_OUT=4, m0 issues 5 Gets with no D responses.
  - Response: 4 accepted and s_a_ready[0] stays 0. One AccessAckData returns, then the 5th is accepted the following cycle.
- Backpressure:
  - Stimulus: m_a_ready=0 for 3 cycles while m_a_valid=1.
  - Response: m_a_pkt stable and all s_a_ready=0. The D response for m1 with s_d_ready[1]=0 gives m_d_ready=0.
- Reset:
  - Stimulus: assert reset on beat 2 of a 4-beat Put.
  - Response: next cycle m_a_valid=0, lock=0, out_cnt=0. A fresh m0 Get is granted with rr_ptr=0.
